// File: rtl/apb_mem_arbiter.sv
// Two-requester round-robin front end driving a single APB memory slave.
// Define APB_ARB_TIMEOUT_EN to abort ACCESS phases that wait TIMEOUT_CYCLES without PREADY.
module apb_mem_arbiter #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              req0_valid,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  output logic              rsp0_err,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic              rsp1_err,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t state, state_nxt;
  logic   last_grant;
  logic   cur_grant;
  logic   grant;
  logic   accept;
  logic   done;
  logic   timeout;

  always_comb begin
    grant = req1_valid;
    if (req0_valid && req1_valid) grant = ~last_grant;
  end

  // Gated by PRESETn so the combinational strobes are also 0 while reset is held.
  assign accept     = (state == IDLE) && (req0_valid || req1_valid) && PRESETn;
  assign req0_ready = accept && !grant;
  assign req1_ready = accept &&  grant;

  assign PSEL    = (state != IDLE);
  assign PENABLE = (state == ACCESS);
  assign done    = (state == ACCESS) && (PREADY || timeout);

`ifdef APB_ARB_TIMEOUT_EN
  localparam int unsigned TCNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TCNT_W-1:0] tcnt;

  assign timeout = (state == ACCESS) && !PREADY && (tcnt == TCNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      tcnt <= '0;
    end else if ((state == ACCESS) && !PREADY && !timeout) begin
      tcnt <= tcnt + 1'b1;
    end else begin
      tcnt <= '0;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (PREADY || timeout) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      cur_grant  <= 1'b0;
      PWRITE     <= 1'b0;
      PADDR      <= '0;
      PWDATA     <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        last_grant <= grant;
        cur_grant  <= grant;
        PWRITE     <= grant ? req1_write : req0_write;
        PADDR      <= grant ? req1_addr  : req0_addr;
        PWDATA     <= grant ? req1_wdata : req0_wdata;
      end
    end
  end

  // A timed-out transfer completes with err=1 and zero data.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      rsp0_valid <= 1'b0;
      rsp0_rdata <= '0;
      rsp0_err   <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp1_rdata <= '0;
      rsp1_err   <= 1'b0;
    end else begin
      rsp0_valid <= done && !cur_grant;
      rsp1_valid <= done &&  cur_grant;
      if (done && !cur_grant) begin
        rsp0_err   <= PREADY ? PSLVERR : 1'b1;
        rsp0_rdata <= (PREADY && !PWRITE) ? PRDATA : '0;
      end
      if (done && cur_grant) begin
        rsp1_err   <= PREADY ? PSLVERR : 1'b1;
        rsp1_rdata <= (PREADY && !PWRITE) ? PRDATA : '0;
      end
    end
  end

endmodule

// File: tb/tb_apb_mem_arbiter.sv
// Self-checking bench for apb_mem_arbiter: directed scenarios plus randomized traffic
// against a transaction-level model and a memory-backed APB slave.
module tb_apb_mem_arbiter;
  localparam int TO = 16;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic [1:0]  rv, rw;
  logic [31:0] ra [2];
  logic [31:0] rd [2];
  logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err;
  logic [31:0] rsp0_rdata, rsp1_rdata;
  logic        PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic [1:0]  rdy, rspv;

  assign rdy  = {req1_ready, req0_ready};
  assign rspv = {rsp1_valid, rsp0_valid};

  int tests = 0;
  int fails = 0;
  bit rand_waits, rand_err;
  int fixed_wait;
  logic [31:0] smem [logic [31:0]];

  apb_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req0_valid(rv[0]), .req0_write(rw[0]), .req0_addr(ra[0]), .req0_wdata(rd[0]), .req0_ready(req0_ready),
    .req1_valid(rv[1]), .req1_write(rw[1]), .req1_addr(ra[1]), .req1_wdata(rd[1]), .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pick_addr();
    if ($urandom_range(0, 9) == 0) return 32'h400;
    return 32'($urandom_range(0, 15)) << 2;
  endfunction

  // APB slave: memory-backed, programmable wait states, always errors on 0x400.
  initial begin : slave
    int acc, wait_n;
    acc = 0; wait_n = 0;
    PREADY = 1'b0; PRDATA = '0; PSLVERR = 1'b0;
    forever begin
      @(posedge PCLK); #1;
      if (PSEL && PENABLE) begin
        PREADY = (acc >= wait_n);
        acc++;
      end else begin
        PREADY = 1'b0;
        acc = 0;
        wait_n = rand_waits ? int'($urandom_range(0, 3)) : fixed_wait;
      end
      PRDATA  = smem.exists(PADDR) ? smem[PADDR] : 32'h0;
      PSLVERR = (PADDR == 32'h400) || (rand_err && $urandom_range(0, 7) == 0);
    end
  end

  always @(negedge PCLK)
    if (PRESETn && PSEL && PENABLE && PREADY && PWRITE) smem[PADDR] = PWDATA;

  // Transaction-level model: one transfer in flight, age counts cycles since acceptance.
  bit          m_busy, m_last, m_pend, m_wr;
  int          m_age, m_who, m_pwho;
  logic [31:0] m_addr, m_data, m_paddr, m_pwdata;
  logic        m_pwrite;
  logic [1:0]  m_err;
  logic [31:0] m_rdata [2];
  logic [31:0] mmem [logic [31:0]];

  task automatic model_done(input bit by_ready);
    m_pend = 1'b1; m_pwho = m_who; m_busy = 1'b0;
    if (by_ready) begin
      m_err[m_who]   = PSLVERR;
      m_rdata[m_who] = m_wr ? 32'h0 : (mmem.exists(m_addr) ? mmem[m_addr] : 32'h0);
      if (m_wr) mmem[m_addr] = m_data;
    end else begin
      m_err[m_who]   = 1'b1;
      m_rdata[m_who] = 32'h0;
    end
  endtask

  always @(negedge PCLK) begin : compare
    logic [1:0] e_rdy;
    int g;
    bit gv;
    if (!PRESETn) begin
      m_busy = 0; m_last = 1; m_pend = 0; m_age = 0; m_who = 0; m_pwho = 0;
      m_pwrite = 0; m_paddr = '0; m_pwdata = '0; m_err = '0;
      m_rdata[0] = '0; m_rdata[1] = '0;
    end
    e_rdy = '0; gv = 0; g = 0;
    if (PRESETn && !m_busy && rv != 2'b00) begin
      gv = 1;
      g  = (rv == 2'b11) ? (m_last ? 0 : 1) : (rv[1] ? 1 : 0);
      e_rdy[g] = 1'b1;
    end
    chk("bus", {PSEL, PENABLE, PWRITE, PADDR, PWDATA},
        {m_busy, m_busy && m_age >= 2, m_pwrite, m_paddr, m_pwdata});
    chk("ready", rdy, e_rdy);
    chk("rsp0", {rsp0_valid, rsp0_err, rsp0_rdata}, {m_pend && m_pwho == 0, m_err[0], m_rdata[0]});
    chk("rsp1", {rsp1_valid, rsp1_err, rsp1_rdata}, {m_pend && m_pwho == 1, m_err[1], m_rdata[1]});
    if (PRESETn) begin
      m_pend = 0;
      if (gv) begin
        m_busy = 1; m_age = 1; m_who = g; m_last = (g == 1);
        m_wr = rw[g]; m_addr = ra[g]; m_data = rd[g];
        m_pwrite = m_wr; m_paddr = m_addr; m_pwdata = m_data;
      end else if (m_busy && m_age >= 2 && PREADY) begin
        model_done(1'b1);
`ifdef APB_ARB_TIMEOUT_EN
      end else if (m_busy && m_age >= 2 && m_age - 1 == TO) begin
        model_done(1'b0);
`endif
      end else if (m_busy) begin
        m_age++;
      end
    end
  end

  int          lat;
  logic        e;
  logic [31:0] d;
  logic [1:0]  s1, s2;
  bit          ok;
  int          got;
  logic [3:0]  seq;

  task automatic do_xfer(input int n, input bit wr, input logic [31:0] addr, input logic [31:0] data);
    bit acc;
    lat = -1; e = 1'b0; d = '0; s1 = '0; s2 = '0;
    @(posedge PCLK); #1;
    rv[n] = 1'b1; rw[n] = wr; ra[n] = addr; rd[n] = data;
    acc = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge PCLK);
      if (rdy[n]) begin acc = 1; break; end
    end
    @(posedge PCLK); #1;
    rv[n] = 1'b0;
    if (!acc) begin chk("accept_bound", 0, 1); return; end
    acc = 0;
    for (int k = 1; k < 60; k++) begin
      @(negedge PCLK);
      if (k == 1) s1 = {PSEL, PENABLE};
      if (k == 2) s2 = {PSEL, PENABLE};
      chk("rsp_other_quiet", rspv[1-n], 1'b0);
      if (rspv[n]) begin
        lat = k; e = n ? rsp1_err : rsp0_err; d = n ? rsp1_rdata : rsp0_rdata;
        acc = 1; break;
      end
    end
    if (!acc) chk("rsp_bound", 0, 1);
  endtask

  task automatic rand_req(input int n, input bit acc);
    if (rv[n] && (acc || $urandom_range(0, 15) == 0)) rv[n] = 1'b0;
    else if (!rv[n] && $urandom_range(0, 1) == 1) begin
      rv[n] = 1'b1; rw[n] = 1'($urandom_range(0, 1)); ra[n] = pick_addr(); rd[n] = $urandom;
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
    $fatal(1);
  end

  initial begin : main
    bit a0, a1;
    PRESETn = 1'b0; rv = '0; rw = '0;
    ra[0] = '0; ra[1] = '0; rd[0] = '0; rd[1] = '0;
    rand_waits = 0; rand_err = 0; fixed_wait = 0;
    @(negedge PCLK);
    chk("reset_outputs", {PSEL, PENABLE, PWRITE, PADDR, PWDATA, rdy, rspv, rsp0_err, rsp1_err}, '0);
    repeat (3) @(posedge PCLK);
    #1 PRESETn = 1'b1;

    do_xfer(0, 1'b1, 32'h10, 32'hA5A5_0001);
    chk("wr_setup_phase", s1, 2'b10);
    chk("wr_access_phase", s2, 2'b11);
    chk("wr_latency", lat, 3);
    chk("wr_err", e, 1'b0);

    do_xfer(1, 1'b0, 32'h10, 32'h0);
    chk("rd_latency", lat, 3);
    chk("rd_data", d, 32'hA5A5_0001);
    chk("rd_err", e, 1'b0);

    fixed_wait = 3;
    do_xfer(0, 1'b1, 32'h30, 32'h1234_5678);
    chk("wait3_latency", lat, 6);
    do_xfer(1, 1'b0, 32'h30, 32'h0);
    chk("wait3_rd_data", d, 32'h1234_5678);
    fixed_wait = 0;
    do_xfer(1, 1'b0, 32'h400, 32'h0);
    chk("slverr_err", e, 1'b1);
    chk("slverr_latency", lat, 3);

    // Reset while in ACCESS; req0 holds the last grant going in.
    fixed_wait = 5;
    @(posedge PCLK); #1;
    rv[0] = 1'b1; rw[0] = 1'b1; ra[0] = 32'h40; rd[0] = 32'hDEAD_0044;
    ok = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge PCLK);
      if (rdy[0]) begin ok = 1; break; end
    end
    chk("rst_accept", ok, 1'b1);
    @(posedge PCLK); #1; rv[0] = 1'b0;
    @(negedge PCLK);
    @(negedge PCLK);
    #2 PRESETn = 1'b0;
    #1;
    chk("rst_async_ctrl", {PSEL, PENABLE, PWRITE, rdy, rspv, rsp0_err, rsp1_err}, '0);
    chk("rst_async_data", {PADDR, PWDATA, rsp0_rdata, rsp1_rdata}, '0);
    repeat (2) @(posedge PCLK);
    #3 PRESETn = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge PCLK);
      chk("no_rsp_after_reset", rspv, 2'b00);
    end
    fixed_wait = 0;

    @(posedge PCLK); #1;
    rv = 2'b11; rw = 2'b01; ra[0] = 32'h20; ra[1] = 32'h24; rd[0] = $urandom; rd[1] = $urandom;
    got = 0; seq = '0;
    for (int k = 0; k < 60 && got < 4; k++) begin
      @(negedge PCLK);
      if (rdy[0]) begin seq = {seq[2:0], 1'b0}; got++; end
      else if (rdy[1]) begin seq = {seq[2:0], 1'b1}; got++; end
      @(posedge PCLK); #1;
      rd[0] = $urandom; rd[1] = $urandom;
    end
    rv = 2'b00;
    chk("tie_grant_count", got, 4);
    chk("tie_grant_order", seq, 4'b0101);
    repeat (8) @(posedge PCLK);

`ifdef APB_ARB_TIMEOUT_EN
    fixed_wait = 1000;
    do_xfer(0, 1'b0, 32'h50, 32'h0);
    chk("timeout_latency", lat, TO + 2);
    chk("timeout_err", e, 1'b1);
    chk("timeout_rdata", d, 32'h0);
    fixed_wait = 0;
`endif

    rand_waits = 1; rand_err = 1;
    @(posedge PCLK); #1;
    for (int c = 0; c < 2000; c++) begin
      @(negedge PCLK);
      a0 = rdy[0]; a1 = rdy[1];
      @(posedge PCLK); #1;
      rand_req(0, a0);
      rand_req(1, a1);
    end
    rv = 2'b00;
    repeat (20) @(posedge PCLK);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
